// File: rtl/seq_signed_divider_if.sv
// Operand/result handshake bundle for the iterative signed divider.
// The master drives operands and out_ready; the slave returns results.
interface seq_signed_divider_if #(
  parameter int N = 10,
  parameter int W = 5
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] dividend;
  logic signed [W-1:0] divisor;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] quotient;
  logic signed [W-1:0] remainder;
  logic                div_by_zero;
  logic                overflow;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero,
    output overflow
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring division on magnitudes,
// one quotient bit per clock, signs applied in a final fix-up cycle.
module seq_signed_divider #(
  parameter int N = 10,
  parameter int W = 5
) (
  input logic                 clk,
  input logic                 rst,
  seq_signed_divider_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // acc holds the dividend magnitude; quotient bits shift in
  // from the bottom as dividend bits leave from the top.
  logic [N-1:0]  acc;
  logic [W-1:0]  pr;
  logic [W-1:0]  mag_b;
  logic          sign_a;
  logic          sign_b;
  logic          zero_b;
  logic          ovf;
  logic [CW-1:0] cnt;

  logic [N-1:0]  quo_r;
  logic [W-1:0]  rem_r;
  logic          dz_r;
  logic          ov_r;

  logic [N-1:0]  mag_a_in;
  logic [W-1:0]  mag_b_in;
  logic          ovf_in;
  logic [W:0]    shifted;
  logic [W-1:0]  trial;
  logic          q_bit;

  // Operand magnitudes and the one restoring-division step.
  // -2^(N-1) negates to 2^(N-1), which still fits N unsigned bits.
  always_comb begin
    mag_a_in = bus.dividend;
    if (bus.dividend[N-1])
      mag_a_in = ~bus.dividend + 1'b1;
    mag_b_in = bus.divisor;
    if (bus.divisor[W-1])
      mag_b_in = ~bus.divisor + 1'b1;
    ovf_in = (bus.dividend == {1'b1, {(N-1){1'b0}}})
          && (&bus.divisor);
    shifted = {pr, acc[N-1]};
    q_bit   = (shifted >= {1'b0, mag_b});
    trial   = shifted[W-1:0] - mag_b;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; the output handshake and a new accept
  // can never share a cycle because DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, then sign-fix into
  // the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      pr     <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      zero_b <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      dz_r   <= 1'b0;
      ov_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc    <= mag_a_in;
            mag_b  <= mag_b_in;
            sign_a <= bus.dividend[N-1];
            sign_b <= bus.divisor[W-1];
            zero_b <= (bus.divisor == '0);
            ovf    <= ovf_in;
            pr     <= '0;
            cnt    <= CW'(N - 1);
          end
        end
        CALC: begin
          acc <= {acc[N-2:0], q_bit};
          pr  <= q_bit ? trial : shifted[W-1:0];
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          dz_r <= zero_b;
          ov_r <= ovf && !zero_b;
          if (zero_b) begin
            quo_r <= '0;
            rem_r <= '0;
          end else if (ovf) begin
            quo_r <= {1'b0, {(N-1){1'b1}}};
            rem_r <= '0;
          end else begin
            quo_r <= (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
            rem_r <= sign_a ? (~pr + 1'b1) : pr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ov_r;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: directed vector table, handshake
// corner sequences, and a divisor sweep against an integer model.
module tb_seq_signed_divider;

  localparam int N = 10;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_signed_divider_if #(.N(N), .W(W)) bus ();

  seq_signed_divider #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [N-1:0] a;
    logic signed [W-1:0] b;
    logic signed [N-1:0] q;
    logic signed [W-1:0] r;
    logic                dz;
    logic                ov;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic void ref_div(
    input int a, input int b,
    output int q, output int r,
    output int dz, output int ov);
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q = 0; r = 0; dz = 1;
    end else if (a == -512 && b == -1) begin
      q = 511; r = 0; ov = 1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // One full transaction; lat counts edges from the accept
  // edge (inclusive) to the edge that raises out_valid.
  task automatic do_op(
    input  logic signed [N-1:0] a,
    input  logic signed [W-1:0] b,
    input  int stall,
    output logic signed [N-1:0] q,
    output logic signed [W-1:0] r,
    output logic dz,
    output logic ov,
    output int lat,
    output int stable);
    int guard;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
    ov = bus.overflow;
    stable = 1;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.quotient !== q ||
          bus.remainder !== r || bus.in_ready !== 1'b0)
        stable = 0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    logic signed [N-1:0] q;
    logic signed [W-1:0] r;
    logic signed [N-1:0] ra;
    logic dz;
    logic ov;
    int lat;
    int st;
    int eq, er, edz, eov;
    int guard;

    vecs[0]  = '{ 100,   7,   14,  2, 1'b0, 1'b0};
    vecs[1]  = '{-100,   7,  -14, -2, 1'b0, 1'b0};
    vecs[2]  = '{ 100,  -7,  -14,  2, 1'b0, 1'b0};
    vecs[3]  = '{-100,  -7,   14, -2, 1'b0, 1'b0};
    vecs[4]  = '{-512,  -1,  511,  0, 1'b0, 1'b1};
    vecs[5]  = '{-512,   1, -512,  0, 1'b0, 1'b0};
    vecs[6]  = '{  37,   0,    0,  0, 1'b1, 1'b0};
    vecs[7]  = '{ 511, -16,  -31, 15, 1'b0, 1'b0};
    vecs[8]  = '{-512, -16,   32,  0, 1'b0, 1'b0};
    vecs[9]  = '{   0,   5,    0,  0, 1'b0, 1'b0};
    vecs[10] = '{  -1,  15,    0, -1, 1'b0, 1'b0};
    vecs[11] = '{ 511,  15,   34,  1, 1'b0, 1'b0};
    vecs[12] = '{-512,  15,  -34, -2, 1'b0, 1'b0};
    vecs[13] = '{   7,   7,    1,  0, 1'b0, 1'b0};
    vecs[14] = '{-512,   0,    0,  0, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_quotient", int'(bus.quotient), 0);
    chk("rst_remainder", int'(bus.remainder), 0);
    chk("rst_flags",
        int'({bus.div_by_zero, bus.overflow}), 0);

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].a, vecs[i].b, i % 3,
            q, r, dz, ov, lat, st);
      chk($sformatf("v%0d_q", i), int'(q), int'(vecs[i].q));
      chk($sformatf("v%0d_r", i), int'(r), int'(vecs[i].r));
      chk($sformatf("v%0d_dz", i), int'(dz), int'(vecs[i].dz));
      chk($sformatf("v%0d_ov", i), int'(ov), int'(vecs[i].ov));
      chk($sformatf("v%0d_lat", i), lat, 12);
      if (i % 3 != 0)
        chk($sformatf("v%0d_stall", i), st, 1);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i),
          int'({bus.in_ready, bus.out_valid}), 2);
    end

    // Stall in DONE with a stray in_valid pulse, then an
    // in_valid coinciding with the output handshake.
    @(negedge clk);
    bus.dividend = 10'sd100;
    bus.divisor  = 5'sd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("s5_reached_done", int'(bus.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.dividend = 10'sd3;
        bus.divisor  = 5'sd1;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      chk($sformatf("s5_hold_ov_%0d", k),
          int'(bus.out_valid), 1);
      chk($sformatf("s5_hold_ir_%0d", k),
          int'(bus.in_ready), 0);
      chk($sformatf("s5_hold_q_%0d", k),
          int'(bus.quotient), 14);
      chk($sformatf("s5_hold_r_%0d", k),
          int'(bus.remainder), 2);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("s5_after_in_ready", int'(bus.in_ready), 1);
    chk("s5_after_out_valid", int'(bus.out_valid), 0);
    repeat (2) @(negedge clk);
    chk("s5_still_idle", int'(bus.in_ready), 1);

    // Reset during the fourth CALC cycle.
    @(negedge clk);
    bus.dividend = 10'sd100;
    bus.divisor  = 5'sd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("s6_in_ready", int'(bus.in_ready), 1);
    chk("s6_out_valid", int'(bus.out_valid), 0);
    chk("s6_quotient", int'(bus.quotient), 0);
    chk("s6_remainder", int'(bus.remainder), 0);
    repeat (14) @(negedge clk);
    chk("s6_no_result", int'(bus.out_valid), 0);
    do_op(10'sd15, -5'sd16, 0, q, r, dz, ov, lat, st);
    chk("s6_next_q", int'(q), 0);
    chk("s6_next_r", int'(r), 15);
    chk("s6_next_lat", lat, 12);

    // Every divisor against random dividends and stalls.
    for (int b = -16; b < 16; b++) begin
      for (int j = 0; j < 8; j++) begin
        if (j == 0)
          ra = -10'sd512;
        else
          ra = 10'($urandom_range(0, 1023));
        ref_div(int'(ra), b, eq, er, edz, eov);
        do_op(ra, 5'(b), int'($urandom_range(0, 3)),
              q, r, dz, ov, lat, st);
        if (int'(q) != eq || int'(r) != er ||
            int'(dz) != edz || int'(ov) != eov ||
            lat != 12 || st != 1)
          $display("FAIL sweep a=%0d b=%0d q=%0d/%0d r=%0d/%0d",
                   ra, b, q, eq, r, er);
        chk("sweep_q", int'(q), eq);
        chk("sweep_r", int'(r), er);
        chk("sweep_flags", int'({dz, ov}), (edz << 1) | eov);
        chk("sweep_lat", lat, 12);
        chk("sweep_stall", st, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_bad);
    $finish;
  end

endmodule
